fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the asynchronous instruction ROM.
- Owns the program counter and drives the ROM word address and read enable.
- Captures the ROM output into a one-entry registered buffer and presents it to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushes the buffered instruction on redirect, and counts delivered instructions.

Parameters:
- TAM_POSICIONES, 1024: ROM depth in words; ROM address width AW = $clog2(TAM_POSICIONES).
- TAM_PALABRA, 32: instruction width in bits.
- RESET_PC, 32'h0000_0000: byte address fetched first after reset; must be word aligned.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- FETCH_EN  in  1  1 = fetching permitted; 0 = no new ROM reads, buffer retained.
- BRANCH_TAKEN  in  1  single-cycle redirect pulse from execute.
- BRANCH_TARGET  in  32  redirect byte address, sampled when BRANCH_TAKEN=1.
- INS_ADDRESS  out  AW  ROM word address = PC[AW+1:2]; combinational from the PC register.
- READ_EN  out  1  ROM read enable; combinational.
- ROM_DATA  in  TAM_PALABRA  ROM output (valid in the same cycle, asynchronous read).
- INSTR_OUT  out  TAM_PALABRA  buffered instruction.
- PC_OUT  out  32  byte address of INSTR_OUT.
- INSTR_VALID  out  1  buffer holds a deliverable instruction.
- INSTR_READY  in  1  decode accepts INSTR_OUT at this edge when INSTR_VALID=1.
- MISALIGN_ERR  out  1  sticky flag: a redirect target had bits[1:0] != 0.
- FETCH_COUNT  out  32  number of completed handshakes, wraps at 2^32.

Behaviour:
- Reset values (RESET=1 at an edge): PC=RESET_PC, state=IDLE, INSTR_VALID=0, INSTR_OUT=0, PC_OUT=0, MISALIGN_ERR=0, FETCH_COUNT=0. READ_EN=0 while in IDLE.
- Reset asserted mid-operation discards the buffer and any pending redirect.
- FSM states: IDLE, RUN, HALTED (HALTED exists only with the optional feature).
  - IDLE -> RUN on the first edge after reset release.
  - RUN has no exit except reset, or entry to HALTED.
- Transfer: a handshake completes when INSTR_VALID & INSTR_READY & !BRANCH_TAKEN; FETCH_COUNT increments by 1 on that edge.
- Load condition in RUN: load = FETCH_EN & !BRANCH_TAKEN & (!INSTR_VALID | INSTR_READY).
  - READ_EN = load.
  - On the load edge: INSTR_OUT<=ROM_DATA, PC_OUT<=PC, INSTR_VALID<=1, PC<=PC+4.
  - Throughput is one instruction per cycle; latency from PC to INSTR_VALID is 1 cycle.
- Stall: INSTR_VALID=1 & INSTR_READY=0 -> READ_EN=0; PC, INSTR_OUT and PC_OUT hold.
- Drain: FETCH_EN=0 with a transfer -> INSTR_VALID<=0; PC holds.
- Redirect (highest priority below reset): BRANCH_TAKEN=1 -> INSTR_VALID<=0, PC<={BRANCH_TARGET[31:2],2'b00}, READ_EN=0, no transfer counted.
  - Decode must ignore INSTR_READY in that cycle; the buffered instruction is younger than the branch and is killed.
  - If BRANCH_TARGET[1:0] != 0, MISALIGN_ERR<=1 and it stays set until reset.
  - The target is fetched on the next cycle.
- Wrap-around: PC is a 32-bit modulo adder; INS_ADDRESS truncates to AW bits, so PC 4*TAM_POSICIONES aliases to word 0. No error is raised.
- Redirect in IDLE: honoured; PC is updated and RUN begins from the target.

Optional Feature:
- Macro: FETCH_HALT_ON_EBREAK_EN.
- Defined:
  - In RUN, a load whose ROM_DATA == 32'h0010_0073 (EBREAK) still loads the instruction normally, then the FSM enters HALTED.
  - In HALTED: READ_EN=0, PC frozen; the buffered EBREAK is still delivered by handshake; BRANCH_TAKEN is ignored. Only reset exits.
  - Adds output HALTED_O (1 bit, reset 0, 1 while in HALTED).
- Undefined: EBREAK is fetched like any instruction; no HALTED state and no HALTED_O port.

Decomposition:
- Package fetch_pkg holds:
  - state enum fetch_state_t {IDLE, RUN, HALTED};
  - constant EBREAK_INSN = 32'h0010_0073;
  - constant INSN_BYTES = 4;
  - default RESET_PC.
- One natural sub-module, fetch_pc_gen: holds the PC register; performs next-PC selection (reset / redirect-aligned / +4 / hold) and misalignment detection; outputs PC and INS_ADDRESS.
- The FSM, buffer and counter stay in fetch_ctrl.

Test Plan:
- Reset release with FETCH_EN=1, INSTR_READY=1, ROM word k = k -> INSTR_VALID rises 1 cycle after IDLE; PC_OUT=0,4,8,… and INSTR_OUT=0,1,2,… on consecutive cycles; FETCH_COUNT=10 after 10 transfers.
- INSTR_READY=0 for 3 cycles while INSTR_VALID=1 at PC_OUT=0x8 -> READ_EN=0, INSTR_OUT/PC_OUT held for 3 cycles; next deliveries are PC 0x8 then 0xC, with no skipped or duplicated word.
- BRANCH_TAKEN with target 0x40 while the buffer holds PC 0x10 and READY=1 -> FETCH_COUNT not incremented; INSTR_VALID=0 next cycle; PC_OUT=0x40 the cycle after.
- Redirect target 0x42 -> fetch from 0x40; MISALIGN_ERR=1, held through later aligned branches until RESET.
- TAM_POSICIONES=16, straight-line run from PC 0x3C -> next PC_OUT=0x40 with INS_ADDRESS=0 and INSTR_OUT = ROM word 0.
- FETCH_HALT_ON_EBREAK_EN defined, ROM word 3 = 0x00100073 -> EBREAK delivered at PC_OUT=0xC, then READ_EN=0 permanently; HALTED_O=1; a later BRANCH_TAKEN has no effect; RESET clears HALTED_O.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    // Sequencer states; HALTED is only reachable when FETCH_HALT_ON_EBREAK_EN is defined
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] EBREAK_INSN      = 32'h0010_0073;
    localparam logic [31:0] INSN_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter for the fetch sequencer: next-PC selection
// (reset / aligned redirect / +4 / hold) and sticky misaligned-target flag.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int          TAM_POSICIONES = 1024,
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_redirect,
    input  logic [31:0]                       i_target,
    input  logic                              i_advance,
    output logic [31:0]                       o_pc,
    output logic [$clog2(TAM_POSICIONES)-1:0] o_ins_address,
    output logic                              o_misalign_err
);

    localparam int AW = $clog2(TAM_POSICIONES);

    logic [31:0] r_pc;
    logic        r_misalign_err;

    // PC update: redirect wins over sequential advance; the low target bits are dropped
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc           <= RESET_PC;
            r_misalign_err <= 1'b0;
        end else if (i_redirect) begin
            r_pc <= align_word(i_target);
            if (i_target[1:0] != 2'b00) begin
                r_misalign_err <= 1'b1;
            end
        end else if (i_advance) begin
            r_pc <= r_pc + INSN_BYTES;
        end
    end

    // Word address truncates, so the PC aliases modulo the ROM size
    assign o_pc           = r_pc;
    assign o_ins_address  = r_pc[AW+1:2];
    assign o_misalign_err = r_misalign_err;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the asynchronous ROM, buffers one
// instruction for decode under valid/ready, handles redirects and counts
// delivered instructions.
// Optional feature macro: FETCH_HALT_ON_EBREAK_EN (halt after fetching EBREAK,
// adds HALTED_O output).
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          TAM_POSICIONES = 1024,
    parameter int          TAM_PALABRA    = 32,
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              FETCH_EN,
    input  logic                              BRANCH_TAKEN,
    input  logic [31:0]                       BRANCH_TARGET,
    output logic [$clog2(TAM_POSICIONES)-1:0] INS_ADDRESS,
    output logic                              READ_EN,
    input  logic [TAM_PALABRA-1:0]            ROM_DATA,
    output logic [TAM_PALABRA-1:0]            INSTR_OUT,
    output logic [31:0]                       PC_OUT,
    output logic                              INSTR_VALID,
    input  logic                              INSTR_READY,
    output logic                              MISALIGN_ERR,
    output logic [31:0]                       FETCH_COUNT
`ifdef FETCH_HALT_ON_EBREAK_EN
    ,
    output logic                              HALTED_O
`endif
);

    fetch_state_t           r_state;
    logic [TAM_PALABRA-1:0] r_instr;
    logic [31:0]            r_pc_out;
    logic                   r_valid;
    logic [31:0]            r_count;

    logic                   w_halted;
    logic                   w_redirect;
    logic                   w_load;
    logic                   w_transfer;
    logic [31:0]            w_pc;

`ifdef FETCH_HALT_ON_EBREAK_EN
    assign w_halted = (r_state == HALTED);
`else
    assign w_halted = 1'b0;
`endif

    // Redirects are ignored once halted; otherwise they kill the buffer and block loads
    assign w_redirect = BRANCH_TAKEN & ~w_halted;
    assign w_load     = (r_state == RUN) & FETCH_EN & ~BRANCH_TAKEN & (~r_valid | INSTR_READY);
    assign w_transfer = r_valid & INSTR_READY & ~w_redirect;
    assign READ_EN    = w_load;

    fetch_pc_gen #(
        .TAM_POSICIONES (TAM_POSICIONES),
        .RESET_PC       (RESET_PC)
    ) u_pc_gen (
        .i_clk          (CLK),
        .i_reset        (RESET),
        .i_redirect     (w_redirect),
        .i_target       (BRANCH_TARGET),
        .i_advance      (w_load),
        .o_pc           (w_pc),
        .o_ins_address  (INS_ADDRESS),
        .o_misalign_err (MISALIGN_ERR)
    );

    // Sequencer FSM: leave IDLE on the first edge after reset, optionally halt on EBREAK
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: r_state <= RUN;
                RUN: begin
`ifdef FETCH_HALT_ON_EBREAK_EN
                    if (w_load && (ROM_DATA == TAM_PALABRA'(EBREAK_INSN))) begin
                        r_state <= HALTED;
                    end
`endif
                end
`ifdef FETCH_HALT_ON_EBREAK_EN
                HALTED: r_state <= HALTED;
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    // One-entry instruction buffer: flush on redirect, refill on load, empty on drain
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_pc_out <= '0;
        end else if (w_redirect) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_instr  <= ROM_DATA;
            r_pc_out <= w_pc;
        end else if (w_transfer) begin
            r_valid <= 1'b0;
        end
    end

    // Delivered-instruction counter, wraps naturally at 2^32
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else if (w_transfer) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign INSTR_OUT   = r_instr;
    assign PC_OUT      = r_pc_out;
    assign INSTR_VALID = r_valid;
    assign FETCH_COUNT = r_count;
`ifdef FETCH_HALT_ON_EBREAK_EN
    assign HALTED_O    = w_halted;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 16-word ROM model (word k holds k).
module tb_fetch_ctrl;

    logic        CLK;
    logic        RESET;
    logic        FETCH_EN;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [3:0]  INS_ADDRESS;
    logic        READ_EN;
    logic [31:0] ROM_DATA;
    logic [31:0] INSTR_OUT;
    logic [31:0] PC_OUT;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic        MISALIGN_ERR;
    logic [31:0] FETCH_COUNT;
`ifdef FETCH_HALT_ON_EBREAK_EN
    logic        HALTED_O;
`endif

    logic [31:0] rom [16];
    int          n_assert;
    int          n_fail;

    assign ROM_DATA = rom[INS_ADDRESS];

    fetch_ctrl #(
        .TAM_POSICIONES (16),
        .TAM_PALABRA    (32),
        .RESET_PC       (32'h0000_0000)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .FETCH_EN      (FETCH_EN),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .INS_ADDRESS   (INS_ADDRESS),
        .READ_EN       (READ_EN),
        .ROM_DATA      (ROM_DATA),
        .INSTR_OUT     (INSTR_OUT),
        .PC_OUT        (PC_OUT),
        .INSTR_VALID   (INSTR_VALID),
        .INSTR_READY   (INSTR_READY),
        .MISALIGN_ERR  (MISALIGN_ERR),
        .FETCH_COUNT   (FETCH_COUNT)
`ifdef FETCH_HALT_ON_EBREAK_EN
        ,
        .HALTED_O      (HALTED_O)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Two reset edges, check reset state, then release (next edge leaves IDLE)
    task automatic do_reset();
        RESET = 1'b1;
        BRANCH_TAKEN = 1'b0;
        BRANCH_TARGET = 32'h0;
        FETCH_EN = 1'b1;
        INSTR_READY = 1'b1;
        tick();
        tick();
        chk("rst_valid", {31'b0, INSTR_VALID}, 32'd0);
        chk("rst_instr", INSTR_OUT, 32'd0);
        chk("rst_pc_out", PC_OUT, 32'd0);
        chk("rst_count", FETCH_COUNT, 32'd0);
        chk("rst_misalign", {31'b0, MISALIGN_ERR}, 32'd0);
        chk("rst_read_en", {31'b0, READ_EN}, 32'd0);
`ifdef FETCH_HALT_ON_EBREAK_EN
        chk("rst_halted", {31'b0, HALTED_O}, 32'd0);
`endif
        RESET = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        for (int k = 0; k < 16; k++) rom[k] = k;
        RESET = 1'b1;
        FETCH_EN = 1'b0;
        BRANCH_TAKEN = 1'b0;
        BRANCH_TARGET = 32'h0;
        INSTR_READY = 1'b0;

        // Straight-line run from reset: one instruction per cycle
        do_reset();
        tick();
        chk("idle_exit_valid", {31'b0, INSTR_VALID}, 32'd0);
        chk("run_read_en", {31'b0, READ_EN}, 32'd1);
        chk("run_addr0", {28'b0, INS_ADDRESS}, 32'd0);
        tick();
        chk("first_valid", {31'b0, INSTR_VALID}, 32'd1);
        chk("first_pc", PC_OUT, 32'd0);
        chk("first_instr", INSTR_OUT, 32'd0);
        chk("first_count", FETCH_COUNT, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("seq_pc", PC_OUT, 32'(4 * i));
            chk("seq_instr", INSTR_OUT, 32'(i));
            chk("seq_count", FETCH_COUNT, 32'(i));
        end

        // Stall three cycles with PC 0x8 buffered
        do_reset();
        tick();
        tick();
        tick();
        tick();
        chk("pre_stall_pc", PC_OUT, 32'h8);
        chk("pre_stall_count", FETCH_COUNT, 32'd2);
        INSTR_READY = 1'b0;
        #1;
        chk("stall_read_en", {31'b0, READ_EN}, 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("stall_pc", PC_OUT, 32'h8);
            chk("stall_instr", INSTR_OUT, 32'd2);
            chk("stall_valid", {31'b0, INSTR_VALID}, 32'd1);
            chk("stall_read_en_hold", {31'b0, READ_EN}, 32'd0);
        end
        INSTR_READY = 1'b1;
        tick();
        chk("post_stall_pc", PC_OUT, 32'hC);
        chk("post_stall_instr", INSTR_OUT, 32'd3);
        chk("post_stall_count", FETCH_COUNT, 32'd3);
        tick();
        chk("pre_br_pc", PC_OUT, 32'h10);
        chk("pre_br_count", FETCH_COUNT, 32'd4);

        // Redirect to 0x40 with READY=1: buffered 0x10 is killed, not counted
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h40;
        #1;
        chk("br_read_en", {31'b0, READ_EN}, 32'd0);
        tick();
        chk("br_flush_valid", {31'b0, INSTR_VALID}, 32'd0);
        chk("br_count", FETCH_COUNT, 32'd4);
        BRANCH_TAKEN = 1'b0;
        tick();
        chk("br_tgt_valid", {31'b0, INSTR_VALID}, 32'd1);
        chk("br_tgt_pc", PC_OUT, 32'h40);
        chk("br_tgt_instr", INSTR_OUT, 32'd0);
        chk("br_tgt_count", FETCH_COUNT, 32'd4);
        chk("br_next_addr", {28'b0, INS_ADDRESS}, 32'd1);

        // Misaligned target 0x42 fetches from 0x40 and sets the sticky flag
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h42;
        tick();
        chk("mis_flag", {31'b0, MISALIGN_ERR}, 32'd1);
        chk("mis_valid", {31'b0, INSTR_VALID}, 32'd0);
        chk("mis_count", FETCH_COUNT, 32'd4);
        BRANCH_TAKEN = 1'b0;
        tick();
        chk("mis_pc", PC_OUT, 32'h40);
        chk("mis_instr", INSTR_OUT, 32'd0);
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h8;
        tick();
        BRANCH_TAKEN = 1'b0;
        tick();
        chk("al_pc", PC_OUT, 32'h8);
        chk("al_instr", INSTR_OUT, 32'd2);
        chk("mis_sticky", {31'b0, MISALIGN_ERR}, 32'd1);

        // Wrap-around from 0x3C: 0x40 aliases to ROM word 0
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h3C;
        tick();
        BRANCH_TAKEN = 1'b0;
        tick();
        chk("wrap_pc_3c", PC_OUT, 32'h3C);
        chk("wrap_instr_15", INSTR_OUT, 32'd15);
        chk("wrap_addr0", {28'b0, INS_ADDRESS}, 32'd0);
        tick();
        chk("wrap_pc_40", PC_OUT, 32'h40);
        chk("wrap_instr_0", INSTR_OUT, 32'd0);
        chk("wrap_count", FETCH_COUNT, 32'd5);
        chk("wrap_no_err_change", {31'b0, MISALIGN_ERR}, 32'd1);

        // Drain: FETCH_EN=0 delivers the buffer and holds the PC
        FETCH_EN = 1'b0;
        tick();
        chk("drain_valid", {31'b0, INSTR_VALID}, 32'd0);
        chk("drain_count", FETCH_COUNT, 32'd6);
        chk("drain_addr", {28'b0, INS_ADDRESS}, 32'd1);
        tick();
        chk("drain_hold_addr", {28'b0, INS_ADDRESS}, 32'd1);
        chk("drain_hold_count", FETCH_COUNT, 32'd6);

        // Reset clears the sticky flag; redirect in IDLE is honoured
        do_reset();
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h20;
        tick();
        BRANCH_TAKEN = 1'b0;
        chk("idle_br_valid", {31'b0, INSTR_VALID}, 32'd0);
        tick();
        chk("idle_br_pc", PC_OUT, 32'h20);
        chk("idle_br_instr", INSTR_OUT, 32'd8);
        chk("idle_br_misalign", {31'b0, MISALIGN_ERR}, 32'd0);

`ifdef FETCH_HALT_ON_EBREAK_EN
        // EBREAK at word 3: delivered, then fetch stops and redirects are ignored
        rom[3] = 32'h0010_0073;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("ebrk_pc", PC_OUT, 32'hC);
        chk("ebrk_instr", INSTR_OUT, 32'h0010_0073);
        chk("ebrk_halted", {31'b0, HALTED_O}, 32'd1);
        chk("ebrk_read_en", {31'b0, READ_EN}, 32'd0);
        tick();
        chk("ebrk_delivered_valid", {31'b0, INSTR_VALID}, 32'd0);
        chk("ebrk_count", FETCH_COUNT, 32'd4);
        BRANCH_TAKEN = 1'b1;
        BRANCH_TARGET = 32'h0;
        tick();
        BRANCH_TAKEN = 1'b0;
        chk("ebrk_br_ignored", {28'b0, INS_ADDRESS}, 32'd4);
        chk("ebrk_still_halted", {31'b0, HALTED_O}, 32'd1);
        tick();
        chk("ebrk_no_fetch", {31'b0, INSTR_VALID}, 32'd0);
        RESET = 1'b1;
        tick();
        chk("ebrk_rst_clear", {31'b0, HALTED_O}, 32'd0);
        RESET = 1'b0;
        rom[3] = 32'd3;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
